lane_sched_tx: RTL

LANE_SCHED_TX -- requirements
Module: lane_sched_tx

---
 rtl/lane_sched_tx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/lane_sched_tx.sv
// Four-lane round-robin byte scheduler for a serializer: a COM alignment burst after
// reset, then one granted byte per cycle, with SKP fill and periodic COM when idle.

module lane_sched_tx_lane (
    input  logic valid_i,
    input  logic en_i,
    input  logic arb_on_i,
    input  logic win_i,
    output logic req_o,
    output logic ready_o
);
    // No per-lane storage: a dropped valid simply stops requesting.
    assign req_o   = valid_i & en_i & arb_on_i;
    assign ready_o = req_o & win_i;
endmodule

module lane_sched_tx #(
    parameter int ALIGN_LEN  = 4,
    parameter int SKP_PERIOD = 32
) (
    input  logic       clk_4f,
    input  logic       reset_L,
    input  logic [7:0] data_in0,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic [7:0] data_in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    input  logic [3:0] lane_en,
    output logic       ready_out0,
    output logic       ready_out1,
    output logic       ready_out2,
    output logic       ready_out3,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [1:0] grant,
    output logic       active_out
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int LW        = 2;
    localparam int AW        = (ALIGN_LEN > 1) ? $clog2(ALIGN_LEN) : 1;

    localparam logic [AW-1:0]    ALIGN_LAST = AW'(ALIGN_LEN - 1);
    localparam logic [5:0]       SKP_LAST   = 6'(SKP_PERIOD - 1);
    localparam logic [VEC_W-1:0] SYM_COM    = 8'hBC;
    localparam logic [VEC_W-1:0] SYM_SKP    = 8'h7C;

    localparam logic [1:0] ST_ALIGN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    typedef struct packed {
        logic [VEC_W-1:0] data;
        logic             valid;
        logic [LW-1:0]    grant;
        logic             active;
    } tx_out_t;

    localparam tx_out_t TX_RESET = '{data: SYM_COM, valid: 1'b0, grant: '0, active: 1'b0};

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] align_q, align_d;
    logic [5:0]    idle_q,  idle_d;
    logic [LW-1:0] rr_q,    rr_d;
    tx_out_t       out_q,   out_d;

    logic [NUM_LANES-1:0][VEC_W-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;
    logic [NUM_LANES-1:0]            lane_req;
    logic [NUM_LANES-1:0]            lane_win;
    logic [NUM_LANES-1:0]            lane_ready;
    logic                            arb_on;
    logic                            win_found;
    logic [LW-1:0]                   win_idx;
    logic [LW-1:0]                   cand;

    assign lane_data  = {data_in3, data_in2, data_in1, data_in0};
    assign lane_valid = {valid_in3, valid_in2, valid_in1, valid_in0};
    // Holding ALIGN during reset keeps every pop strobe low without a separate gate.
    assign arb_on     = (state_q != ST_ALIGN);

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            lane_sched_tx_lane u_lane (
                .valid_i (lane_valid[g]),
                .en_i    (lane_en[g]),
                .arb_on_i(arb_on),
                .win_i   (lane_win[g]),
                .req_o   (lane_req[g]),
                .ready_o (lane_ready[g])
            );
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = rr_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = rr_q + LW'(i);
            if (!win_found && lane_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign lane_win = win_found ? (NUM_LANES'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        align_d = align_q;
        idle_d  = idle_q;
        rr_d    = rr_q;
        out_d   = out_q;
        case (state_q)
            ST_ALIGN: begin
                out_d.data  = SYM_COM;
                out_d.valid = 1'b0;
                align_d     = align_q + AW'(1);
                if (align_q == ALIGN_LAST) begin
                    state_d      = ST_IDLE;
                    out_d.active = 1'b1;
                end
            end
            default: begin
                if (win_found) begin
                    state_d     = ST_SEND;
                    out_d.data  = lane_data[win_idx];
                    out_d.valid = 1'b1;
                    out_d.grant = win_idx;
                    rr_d        = win_idx + LW'(1);
                    idle_d      = '0;
                end else begin
                    state_d     = ST_IDLE;
                    out_d.valid = 1'b0;
                    // Every SKP_PERIOD-th consecutive idle cycle carries COM to keep the link aligned.
                    if (idle_q == SKP_LAST) begin
                        out_d.data = SYM_COM;
                        idle_d     = '0;
                    end else begin
                        out_d.data = SYM_SKP;
                        idle_d     = idle_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_ALIGN;
            align_q <= '0;
            idle_q  <= '0;
            rr_q    <= '0;
            out_q   <= TX_RESET;
        end else begin
            state_q <= state_d;
            align_q <= align_d;
            idle_q  <= idle_d;
            rr_q    <= rr_d;
            out_q   <= out_d;
        end
    end

    assign ready_out0 = lane_ready[0];
    assign ready_out1 = lane_ready[1];
    assign ready_out2 = lane_ready[2];
    assign ready_out3 = lane_ready[3];
    assign data_out   = out_q.data;
    assign valid_out  = out_q.valid;
    assign grant      = out_q.grant;
    assign active_out = out_q.active;
endmodule
